// File: rtl/apb_pkg.sv
// Shared definitions for the APB RAM completer: FSM encoding, PPROT bit
// positions and the byte-lane address helper.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } apb_state_e;

    localparam int PPROT_PRIV   = 0;
    localparam int PPROT_NONSEC = 1;
    localparam int PPROT_INSTR  = 2;

    localparam int BYTE_W = 8;

    // Number of paddr bits that select a byte within one data word.
    function automatic int lane_bits(input int data_w);
        return $clog2(data_w / BYTE_W);
    endfunction

endpackage

// File: rtl/apb_ram_core.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// rdata holds the read word for one cycle after rd_en and is zero otherwise.
module apb_ram_core
    import apb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int STRB_W     = DATA_W / 8,
    parameter int MEM_ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [MEM_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [STRB_W-1:0]     wstrb,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**MEM_ADDR_W];

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[addr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else        rdata <= rd_en ? mem[addr] : '0;
    end

endmodule

// File: rtl/apb_ram_completer.sv
// APB completer backed by a local byte-strobed RAM, with programmable wait
// states and an out-of-range error. Define APB_RAM_PROT_CHECK_EN to reject
// unprivileged writes (pprot[0] = 0) with pslverr.
module apb_ram_completer
    import apb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int STRB_W      = DATA_W / 8,
    parameter int MEM_ADDR_W  = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] s_apb_paddr,
    input  logic [2:0]        s_apb_pprot,
    input  logic              s_apb_psel,
    input  logic              s_apb_penable,
    input  logic              s_apb_pwrite,
    input  logic [DATA_W-1:0] s_apb_pwdata,
    input  logic [STRB_W-1:0] s_apb_pstrb,
    output logic              s_apb_pready,
    output logic [DATA_W-1:0] s_apb_prdata,
    output logic              s_apb_pslverr
);

    localparam int LANE_BITS = lane_bits(DATA_W);
    localparam int HI        = MEM_ADDR_W + LANE_BITS;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] word;
        logic                  write;
        logic                  err;
    } req_t;

    apb_state_e            state, state_d;
    logic [3:0]            cnt, cnt_d;
    req_t                  req_q, req_d, req_live;
    logic                  pready_d, pslverr_d;
    logic                  rd_en, wr_en;
    logic                  range_err, prot_err;
    logic [MEM_ADDR_W-1:0] ram_addr;
    logic                  unused_bits;

    assign unused_bits = ^{s_apb_pprot, s_apb_paddr};

    assign range_err = (s_apb_paddr >> HI) != '0;

`ifdef APB_RAM_PROT_CHECK_EN
    assign prot_err = s_apb_pwrite & ~s_apb_pprot[PPROT_PRIV];
`else
    assign prot_err = 1'b0;
`endif

    assign req_live = '{word:  s_apb_paddr[HI-1:LANE_BITS],
                        write: s_apb_pwrite,
                        err:   range_err | prot_err};

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        req_d     = req_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        ram_addr  = req_q.word;
        case (state)
            IDLE: begin
                ram_addr = req_live.word;
                if (s_apb_psel) begin
                    req_d = req_live;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = READY;
                        pready_d  = 1'b1;
                        pslverr_d = req_live.err;
                        rd_en     = !req_live.write && !req_live.err;
                    end else begin
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!s_apb_psel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt == 4'd1) begin
                    state_d   = READY;
                    cnt_d     = '0;
                    pready_d  = 1'b1;
                    pslverr_d = req_q.err;
                    rd_en     = !req_q.write && !req_q.err;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            READY: begin
                // Write commits only on the completion edge, using live data.
                state_d = IDLE;
                wr_en   = s_apb_psel && s_apb_penable && req_q.write && !req_q.err;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            req_q         <= '0;
            s_apb_pready  <= 1'b0;
            s_apb_pslverr <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            req_q         <= req_d;
            s_apb_pready  <= pready_d;
            s_apb_pslverr <= pslverr_d;
        end
    end

    apb_ram_core #(
        .DATA_W     (DATA_W),
        .STRB_W     (STRB_W),
        .MEM_ADDR_W (MEM_ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .rd_en (rd_en),
        .wr_en (wr_en),
        .addr  (ram_addr),
        .wdata (s_apb_pwdata),
        .wstrb (s_apb_pstrb),
        .rdata (s_apb_prdata)
    );

endmodule

// File: doc/apb_ram_completer.md
Name: apb_ram_completer

Overview:
- APB completer (slave) end of the APB interface. Answers requester transfers from a local word-addressed RAM with per-byte write strobes.
- Supports a programmable number of wait states and an error response on out-of-range addresses.
- Used as the standalone DUT-side target for APB requester models, and as a simple register/scratch RAM behind an APB fabric.

Parameters:
- DATA_W, 32, data bus width in bits (8, 16 or 32).
- ADDR_W, 16, byte address width of s_apb_paddr.
- STRB_W, DATA_W/8, byte strobe width.
- MEM_ADDR_W, 8, log2 of RAM depth in words.
- WAIT_CYCLES, 0, wait states inserted before pready (0..15).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- s_apb_paddr  input  ADDR_W  byte address.
- s_apb_pprot  input  3  protection attributes.
- s_apb_psel  input  1  completer select.
- s_apb_penable  input  1  access phase.
- s_apb_pwrite  input  1  1 = write, 0 = read.
- s_apb_pwdata  input  DATA_W  write data.
- s_apb_pstrb  input  STRB_W  write byte strobes.
- s_apb_pready  output  1  transfer completes this cycle.
- s_apb_prdata  output  DATA_W  read data, valid with pready on a read.
- s_apb_pslverr  output  1  error response, valid with pready.

Behaviour:
- Reset:
  - One clock, clk. Reset is asynchronous and active-low (rst_n); release is synchronous to clk.
  - On rst_n low: state = IDLE, pready = 0, prdata = 0, pslverr = 0, wait counter = 0.
  - RAM contents are not reset.
- Address decode:
  - Word index = paddr[MEM_ADDR_W+log2(STRB_W)-1 : log2(STRB_W)].
  - Low byte-lane bits are ignored.
  - If any paddr bit at or above MEM_ADDR_W+log2(STRB_W) is set, the access is out of range (err = 1).
- FSM states: IDLE, WAIT, READY. All outputs are registered.
- IDLE:
  - On psel = 1 (setup cycle; penable ignored here), latch address, pwrite and err.
  - If WAIT_CYCLES == 0: go to READY and set pready = 1. pready is therefore high in the first access cycle (zero-wait transfer, 2 cycles total).
  - Otherwise: load counter = WAIT_CYCLES and go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When counter == 1, go to READY and set pready = 1.
  - Transfer length = 2 + WAIT_CYCLES cycles.
  - psel = 0 while in WAIT (abort): return to IDLE, no write, outputs stay 0.
- READY:
  - pready = 1 for exactly one cycle.
  - pslverr = latched err.
  - prdata = RAM[word] captured on entry for an in-range read; 0 for writes and for errors.
  - Completion edge (psel & penable): for an in-range write, write live pwdata byte lanes where pstrb = 1. Then go to IDLE and clear pready, pslverr and prdata.
  - psel = 0 in READY: return to IDLE with no write.
- Back-to-back: a new setup cycle directly after completion is accepted from IDLE.
- Read-after-write to the same word returns the new data, because the write commits at least one cycle before the read capture.
- Reset mid-transfer: the FSM is forced to IDLE immediately. No partial write occurs; a write commits only on the completion edge.
- pstrb = 0 on a write: completes normally, RAM unchanged, pslverr = 0.

Optional Feature:
- Macro: APB_RAM_PROT_CHECK_EN.
- Defined: a write with pprot[0] = 0 (unprivileged) completes with pslverr = 1 and no RAM update. Unprivileged reads are allowed.
- Not defined: pprot is ignored entirely.

Decomposition:
- Package apb_pkg holds:
  - FSM state encoding localparams (IDLE = 2'd0, WAIT = 2'd1, READY = 2'd2).
  - PPROT bit indices (PRIV = 0, NONSEC = 1, INSTR = 2).
  - Helper constant for byte-lane address bits.
- One sub-module: apb_ram_core, a single-port DATA_W x 2^MEM_ADDR_W RAM with STRB_W byte-enable write and registered read.

Test Plan:
- WAIT_CYCLES = 0: write 0xDEADBEEF to 0x0010 with pstrb = 0xF, then read 0x0010 -> pready in the first access cycle, prdata = 0xDEADBEEF, pslverr = 0.
- WAIT_CYCLES = 3: read 0x0004 -> pready low for 3 access cycles then high for 1; total transfer 5 cycles.
- Byte strobes: write 0x11223344 to 0x0020, then write 0xAABBCCDD with pstrb = 0x5, then read -> 0x11BB33DD.
- Out of range (MEM_ADDR_W = 8, 32-bit): access to 0x0400 -> pslverr = 1, prdata = 0. A read of 0x0000 remains unchanged.
- Abort and reset: psel dropped during WAIT, or rst_n pulsed low mid-WAIT of a write to 0x0008 -> pready never asserts, RAM[2] unchanged, outputs 0 immediately on rst_n low.
- With APB_RAM_PROT_CHECK_EN: write 0x12345678 to 0x000C with pprot = 3'b000 -> pslverr = 1, readback unchanged. Repeat with pprot = 3'b001 -> pslverr = 0, readback 0x12345678.
